// File: rtl/mmio_gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO block: bus width, register
// offsets and the STATUS word layout.
package mmio_gpio_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [1:0]        reg_off_t;

    localparam reg_off_t OFF_SW     = 2'd0;
    localparam reg_off_t OFF_LED    = 2'd1;
    localparam reg_off_t OFF_EDGE   = 2'd2;
    localparam reg_off_t OFF_STATUS = 2'd3;

    // STATUS: bit0 = debounce pending, bit1 = interrupt, upper bits zero.
    function automatic data_t status_word(input logic busy, input logic irq);
        return {{(DATA_W-2){1'b0}}, irq, busy};
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer followed by a shared-counter debouncer; a new switch
// pattern is accepted only after it has been stable for DEBOUNCE_CYCLES cycles.
module switch_debounce
    import mmio_gpio_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] clean,
    output logic              busy
);

    localparam logic [15:0] CNT_LIMIT = DEBOUNCE_CYCLES - 16'd1;
    localparam logic        SINGLE    = (DEBOUNCE_CYCLES == 16'd1);

    logic [DATA_W-1:0] meta_q;
    logic [DATA_W-1:0] sync_q;
    logic [DATA_W-1:0] prev_q;
    logic [DATA_W-1:0] clean_q;
    logic [DATA_W-1:0] clean_d;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;
    logic              differs;
    logic              stable;
    logic              accept;

    assign differs = (sync_q != clean_q);
    assign stable  = (sync_q == prev_q);
    // With a one-cycle window the first differing sample is accepted outright.
    assign accept  = differs && (cnt_q == CNT_LIMIT) && (stable || SINGLE);

    always_comb begin
        cnt_d   = cnt_q + 16'd1;
        clean_d = clean_q;
        if (accept) begin
            cnt_d   = '0;
            clean_d = sync_q;
        end else if (!differs || !stable) begin
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q  <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
            clean_q <= '0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= raw;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clean = clean_q;
    assign busy  = differs;

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: debounced switches, LED register, sticky rising-edge
// capture with interrupt. Edge capture is built only when GPIO_EDGE_CAPTURE_EN is defined.
module mmio_gpio
    import mmio_gpio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR       = 16'hFFF0,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] switches,
    output logic [15:0] leds,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [15:0] rdata,
    output logic        hit,
    output logic        irq
);

    data_t    clean;
    logic     busy;
    logic [15:0] offset_full;
    reg_off_t offset;
    logic     decoded;
    logic     rd_en;
    logic     wr_en;
    data_t    leds_q;
    data_t    leds_d;
    data_t    rdata_q;
    data_t    rdata_d;
    logic     hit_q;
    logic     hit_d;
    data_t    edge_rd;
    logic     irq_bit;
    data_t    rd_mux;

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock(clock),
        .reset(reset),
        .raw  (switches),
        .clean(clean),
        .busy (busy)
    );

    // Offsets are taken modulo 2^16 so a window near the top of memory still decodes.
    assign offset_full = addr - BASE_ADDR;
    assign decoded     = (offset_full[15:2] == 14'd0);
    assign offset      = offset_full[1:0];
    assign rd_en       = re & decoded;
    assign wr_en       = we & decoded;

`ifdef GPIO_EDGE_CAPTURE_EN
    data_t edge_q;
    data_t edge_d;
    data_t clean_prev_q;
    logic  irq_q;
    logic  wr_edge;

    assign wr_edge = wr_en && (offset == OFF_EDGE);

    // A rising edge wins over a same-cycle write-one-to-clear.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_edge
        assign edge_d[gi] = (clean[gi] & ~clean_prev_q[gi]) |
                            (edge_q[gi] & ~(wr_edge & wdata[gi]));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_q       <= '0;
            clean_prev_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            edge_q       <= edge_d;
            clean_prev_q <= clean;
            irq_q        <= |edge_d;
        end
    end

    assign edge_rd = edge_q;
    assign irq_bit = irq_q;
`else
    assign edge_rd = '0;
    assign irq_bit = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (offset)
            OFF_SW:     rd_mux = clean;
            OFF_LED:    rd_mux = leds_q;
            OFF_EDGE:   rd_mux = edge_rd;
            OFF_STATUS: rd_mux = status_word(busy, irq_bit);
            default:    rd_mux = '0;
        endcase
    end

    always_comb begin
        rdata_d = rd_en ? rd_mux : '0;
        hit_d   = rd_en;
        leds_d  = leds_q;
        if (wr_en && (offset == OFF_LED)) begin
            leds_d = wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            leds_q  <= '0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            leds_q  <= leds_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
        end
    end

    assign leds  = leds_q;
    assign rdata = rdata_q;
    assign hit   = hit_q;
    assign irq   = irq_bit;

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed bench for mmio_gpio (DEBOUNCE_CYCLES=4); bus reads push expected
// {hit,rdata} to a scoreboard that is popped one cycle later.
module tb_mmio_gpio;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] switches = '0;
    logic [15:0] leds;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [15:0] rdata;
    logic        hit;
    logic        irq;

`ifdef GPIO_EDGE_CAPTURE_EN
    localparam logic EC = 1'b1;
`else
    localparam logic EC = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [16:0] exp_q[$];
    string       tag_q[$];

    mmio_gpio #(
        .BASE_ADDR      (16'hFFF0),
        .DEBOUNCE_CYCLES(16'd4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .switches(switches),
        .leds    (leds),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .re      (re),
        .rdata   (rdata),
        .hit     (hit),
        .irq     (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One bus cycle, started and finished at a falling edge.
    task automatic bus(input string tag, input logic w, input logic r,
                       input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp_rd);
        logic        exp_hit;
        logic [16:0] e;
        string       t;
        exp_hit = r && (a >= 16'hFFF0) && (a <= 16'hFFF3);
        we = w; re = r; addr = a; wdata = d;
        exp_q.push_back({exp_hit, exp_hit ? exp_rd : 16'h0000});
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "/rdata"}, rdata, e[15:0]);
        check({t, "/hit"}, 16'(hit), 16'(e[16]));
        $display("bus %-14s we=%0b re=%0b addr=%h wdata=%h -> rdata=%h hit=%0b irq=%0b",
                 t, w, r, a, d, rdata, hit, irq);
        @(negedge clock);
        we = 1'b0; re = 1'b0;
    endtask

    function automatic logic [15:0] pat(input int i);
        if (i < 0) return 16'h0007;
        return ((i >> 1) & 1) != 0 ? 16'h0005 : 16'h0007;
    endfunction

    initial begin
        logic busy_exp;

        // Reset with switches already high
        switches = 16'h0007;
        wait_neg(3);
        check("rst/leds", leds, 16'h0000);
        check("rst/rdata", rdata, 16'h0000);
        check("rst/hit", 16'(hit), 16'h0000);
        check("rst/irq", 16'(irq), 16'h0000);
        reset = 1'b1;
        wait_neg(2);
        bus("sw_c3", 1'b0, 1'b1, 16'hFFF0, 16'h0, 16'h0000);
        wait_neg(3);
        bus("sw_c7", 1'b0, 1'b1, 16'hFFF0, 16'h0, 16'h0000);
        bus("sw_c8", 1'b0, 1'b1, 16'hFFF0, 16'h0, 16'h0007);
        bus("status_c9", 1'b0, 1'b1, 16'hFFF3, 16'h0, {14'b0, EC, 1'b0});
        bus("edge_c10", 1'b0, 1'b1, 16'hFFF2, 16'h0, EC ? 16'h0007 : 16'h0000);
        check("irq_set", 16'(irq), 16'(EC));

        // Bouncing 7<->5 every two cycles must not be accepted
        for (int i = 0; i < 20; i++) begin
            switches = pat(i);
            busy_exp = (pat(i - 2) == 16'h0005);
            if ((i % 2) == 0)
                bus("bounce_sw", 1'b0, 1'b1, 16'hFFF0, 16'h0, 16'h0007);
            else
                bus("bounce_stat", 1'b0, 1'b1, 16'hFFF3, 16'h0, {14'b0, EC, busy_exp});
        end
        for (int j = 20; j < 25; j++)
            bus("hold_sw_old", 1'b0, 1'b1, 16'hFFF0, 16'h0, 16'h0007);
        bus("hold_sw_new", 1'b0, 1'b1, 16'hFFF0, 16'h0, 16'h0005);
        bus("edge_nofall", 1'b0, 1'b1, 16'hFFF2, 16'h0, EC ? 16'h0007 : 16'h0000);

        // LED write with same-cycle read returns the old value
        bus("led_wr_rd", 1'b1, 1'b1, 16'hFFF1, 16'hA5A5, 16'h0000);
        check("leds_a5a5", leds, 16'hA5A5);
        bus("led_rd", 1'b0, 1'b1, 16'hFFF1, 16'h0, 16'hA5A5);

        // Write-one-to-clear, then a clear that coincides with bit1 rising
        bus("edge_w1c", 1'b1, 1'b0, 16'hFFF2, 16'h0001, 16'h0);
        bus("edge_rd6", 1'b0, 1'b1, 16'hFFF2, 16'h0, EC ? 16'h0006 : 16'h0000);
        check("irq_after_w1c", 16'(irq), 16'(EC));
        switches = 16'h0007;
        wait_neg(7);
        bus("edge_setclr", 1'b1, 1'b0, 16'hFFF2, 16'h0006, 16'h0);
        bus("edge_rd2", 1'b0, 1'b1, 16'hFFF2, 16'h0, EC ? 16'h0002 : 16'h0000);
        check("irq_after_set", 16'(irq), 16'(EC));

        // Undecoded addresses, idle cycle, writes to read-only registers
        bus("undec_fff4", 1'b0, 1'b1, 16'hFFF4, 16'h0, 16'h0);
        bus("undec_0000", 1'b0, 1'b1, 16'h0000, 16'h0, 16'h0);
        bus("idle", 1'b0, 1'b0, 16'hFFF1, 16'h0, 16'h0);
        bus("wr_sw_ro", 1'b1, 1'b0, 16'hFFF0, 16'hFFFF, 16'h0);
        bus("wr_stat_ro", 1'b1, 1'b0, 16'hFFF3, 16'hFFFF, 16'h0);
        bus("sw_unchanged", 1'b0, 1'b1, 16'hFFF0, 16'h0, 16'h0007);
        bus("stat_unchanged", 1'b0, 1'b1, 16'hFFF3, 16'h0, {14'b0, EC, 1'b0});
        check("leds_kept", leds, 16'hA5A5);

        // Asynchronous reset in the middle of a debounce
        bus("led_wr_ff", 1'b1, 1'b0, 16'hFFF1, 16'h00FF, 16'h0);
        switches = 16'h0003;
        wait_neg(3);
        bus("led_rd_ff", 1'b0, 1'b1, 16'hFFF1, 16'h0, 16'h00FF);
        #1 reset = 1'b0;
        #1;
        check("arst/leds", leds, 16'h0000);
        check("arst/rdata", rdata, 16'h0000);
        check("arst/hit", 16'(hit), 16'h0000);
        check("arst/irq", 16'(irq), 16'h0000);
        wait_neg(2);
        reset = 1'b1;
        wait_neg(6);
        bus("rst2_sw_c7", 1'b0, 1'b1, 16'hFFF0, 16'h0, 16'h0000);
        bus("rst2_sw_c8", 1'b0, 1'b1, 16'hFFF0, 16'h0, 16'h0003);
        bus("rst2_edge", 1'b0, 1'b1, 16'hFFF2, 16'h0, EC ? 16'h0003 : 16'h0000);
        bus("rst2_led", 1'b0, 1'b1, 16'hFFF1, 16'h0, 16'h0000);
        check("rst2_irq", 16'(irq), 16'(EC));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
